acondicionador_botones: RTL and testbench

Upstream input stage for `SelectorDeImagenes`. It takes the five raw, asynchronous, bouncing board push-buttons and turns them into clean single-cycle pulses on `Izquierda`, `Derecha`, `Arriba`, `Abajo` and `Select`. At most one of these pulses is high in any cycle, which is the form the selector consumes. Held direction buttons auto-repeat so the cursor can sweep the 3x3 shape grid.

---
 rtl/acondicionador_botones.sv | 139 +++++++++++++
 tb/tb_acondicionador_botones.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/acondicionador_botones.sv
// Button conditioner: synchronises and debounces five push-buttons, then emits
// mutually exclusive one-cycle pulses with auto-repeat on held directions.
module acondicionador_botones #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 16,
    parameter int unsigned REPEAT_PERIOD   = 8,
    parameter int unsigned CNT_W           = 20
) (
    input  logic Clk,
    input  logic Reset,
    input  logic BtnIzquierda,
    input  logic BtnDerecha,
    input  logic BtnArriba,
    input  logic BtnAbajo,
    input  logic BtnSelect,
    output logic Izquierda,
    output logic Derecha,
    output logic Arriba,
    output logic Abajo,
    output logic Select
);

    localparam int unsigned NB  = 5;
    localparam int unsigned IZQ = 0;
    localparam int unsigned DER = 1;
    localparam int unsigned ARR = 2;
    localparam int unsigned ABA = 3;
    localparam int unsigned SEL = 4;

    localparam logic [CNT_W-1:0] DbLast    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RepDelay  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RepPeriod = CNT_W'(REPEAT_PERIOD - 1);

    logic [NB-1:0]    w_raw;
    logic [NB-1:0]    r_s1, r_s2;
    logic [NB-1:0]    r_stable, w_stable_d;
    logic [NB-1:0]    w_rise;
    logic [CNT_W-1:0] r_cnt   [NB];
    logic [CNT_W-1:0] w_cnt_d [NB];

    logic [3:0]       w_held_q, w_held_d, w_target;
    logic [CNT_W-1:0] r_rep, w_rep_d;
    logic             r_rep_phase, w_rep_phase_d;
    logic             w_rep_hit, w_rep_fire;
    logic [NB-1:0]    w_press_pick, w_win, r_out;

    assign w_raw = {BtnSelect, BtnAbajo, BtnArriba, BtnDerecha, BtnIzquierda};

    always_comb begin
        for (int i = 0; i < NB; i++) begin
            w_stable_d[i] = r_stable[i];
            w_cnt_d[i]    = '0;
            w_rise[i]     = 1'b0;
            if (r_s2[i] != r_stable[i]) begin
                if (r_cnt[i] == DbLast) begin
                    w_stable_d[i] = r_s2[i];
                    w_rise[i]     = r_s2[i];
                end else begin
                    w_cnt_d[i] = r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign w_held_q = r_stable[3:0];
    assign w_held_d = w_stable_d[3:0];

    always_comb begin
        w_target = '0;
        if (w_held_q[ARR])      w_target[ARR] = 1'b1;
        else if (w_held_q[ABA]) w_target[ABA] = 1'b1;
        else if (w_held_q[IZQ]) w_target[IZQ] = 1'b1;
        else if (w_held_q[DER]) w_target[DER] = 1'b1;
    end

    always_comb begin
        w_press_pick = '0;
        if (w_rise[SEL])      w_press_pick[SEL] = 1'b1;
        else if (w_rise[ARR]) w_press_pick[ARR] = 1'b1;
        else if (w_rise[ABA]) w_press_pick[ABA] = 1'b1;
        else if (w_rise[IZQ]) w_press_pick[IZQ] = 1'b1;
        else if (w_rise[DER]) w_press_pick[DER] = 1'b1;
    end

    // The first repeat waits the long delay; later ones use the short period.
    assign w_rep_hit  = r_rep_phase ? (r_rep == RepPeriod) : (r_rep == RepDelay);
    assign w_rep_fire = (|w_held_q) && (w_held_d == w_held_q) && w_rep_hit;

    always_comb begin
        w_win         = '0;
        w_rep_phase_d = r_rep_phase;
        if (|w_rise) begin
            w_win         = w_press_pick;
            w_rep_phase_d = 1'b0;
        end else if (w_rep_fire) begin
            w_win         = {1'b0, w_target};
            w_rep_phase_d = 1'b1;
        end
    end

    always_comb begin
        if ((|w_win) || (w_held_d != w_held_q) || (w_held_d == '0)) begin
            w_rep_d = '0;
        end else begin
            w_rep_d = r_rep + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_s1        <= '0;
            r_s2        <= '0;
            r_stable    <= '0;
            r_rep       <= '0;
            r_rep_phase <= 1'b0;
            r_out       <= '0;
            for (int i = 0; i < NB; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1        <= w_raw;
            r_s2        <= r_s1;
            r_stable    <= w_stable_d;
            r_rep       <= w_rep_d;
            r_rep_phase <= w_rep_phase_d;
            r_out       <= w_win;
            for (int i = 0; i < NB; i++) begin
                r_cnt[i] <= w_cnt_d[i];
            end
        end
    end

    assign Izquierda = r_out[IZQ];
    assign Derecha   = r_out[DER];
    assign Arriba    = r_out[ARR];
    assign Abajo     = r_out[ABA];
    assign Select    = r_out[SEL];

endmodule

// File: tb/tb_acondicionador_botones.sv
// Scoreboard bench for acondicionador_botones: directed presses push expected
// (edge, output) pulses; a forked monitor pops them whenever an output fires.
module tb_acondicionador_botones;

    localparam logic [4:0] M_IZQ = 5'b00001;
    localparam logic [4:0] M_DER = 5'b00010;
    localparam logic [4:0] M_ARR = 5'b00100;
    localparam logic [4:0] M_ABA = 5'b01000;
    localparam logic [4:0] M_SEL = 5'b10000;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic b_izq = 1'b1, b_der = 1'b1, b_arr = 1'b1, b_aba = 1'b1, b_sel = 1'b1;
    logic Izquierda, Derecha, Arriba, Abajo, Select;
    logic [4:0] w_out;

    typedef struct {
        int         edge_n;
        logic [4:0] mask;
    } exp_t;

    exp_t exp_q[$];
    int   edge_cnt = 0;
    int   errors = 0;
    int   checks = 0;
    int   e0, er;

    acondicionador_botones #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (16),
        .REPEAT_PERIOD  (8),
        .CNT_W          (20)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .BtnIzquierda(b_izq),
        .BtnDerecha  (b_der),
        .BtnArriba   (b_arr),
        .BtnAbajo    (b_aba),
        .BtnSelect   (b_sel),
        .Izquierda   (Izquierda),
        .Derecha     (Derecha),
        .Arriba      (Arriba),
        .Abajo       (Abajo),
        .Select      (Select)
    );

    assign w_out = {Select, Abajo, Arriba, Derecha, Izquierda};

    always #5 Clk = ~Clk;

    always @(posedge Clk) edge_cnt <= edge_cnt + 1;

    task automatic expect_pulse(input int e, input logic [4:0] m);
        exp_t x;
        x.edge_n = e;
        x.mask   = m;
        exp_q.push_back(x);
    endtask

    // Returns at the falling edge that follows rising edge number e.
    task automatic wait_edge(input int e);
        while (edge_cnt < e) @(negedge Clk);
    endtask

    task automatic monitor();
        exp_t x;
        forever begin
            @(negedge Clk);
            if (Reset) begin
                checks++;
                if (w_out != 5'b0) begin
                    errors++;
                    $display("FAIL reset_outputs: got %b, want 00000 (edge %0d)", w_out, edge_cnt);
                end
            end else if (w_out != 5'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: got %b at edge %0d, want none",
                             w_out, edge_cnt);
                end else begin
                    x = exp_q.pop_front();
                    if (x.edge_n != edge_cnt || x.mask != w_out) begin
                        errors++;
                        $display("FAIL pulse: got %b at edge %0d, want %b at edge %0d",
                                 w_out, edge_cnt, x.mask, x.edge_n);
                    end
                end
            end
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        // 1: reset with every button held; only Select pulses.
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        e0 = edge_cnt + 1;
        expect_pulse(e0 + 5, M_SEL);
        wait_edge(e0 + 6);
        {b_izq, b_der, b_arr, b_aba, b_sel} = 5'b0;
        repeat (15) @(negedge Clk);

        // 2: clean Derecha press, 10 cycles.
        e0 = edge_cnt + 1;
        b_der = 1'b1;
        expect_pulse(e0 + 5, M_DER);
        wait_edge(e0 + 9);
        b_der = 1'b0;
        repeat (15) @(negedge Clk);

        // 3: bouncing Arriba, then steady high from edge e0+6.
        e0 = edge_cnt + 1;
        expect_pulse(e0 + 11, M_ARR);
        for (int i = 0; i < 6; i++) begin
            b_arr = ~i[0];
            @(negedge Clk);
        end
        b_arr = 1'b1;
        repeat (8) @(negedge Clk);
        b_arr = 1'b0;
        repeat (15) @(negedge Clk);

        // 4: Abajo held 45 cycles -> press plus four repeats.
        e0 = edge_cnt + 1;
        b_aba = 1'b1;
        expect_pulse(e0 + 5, M_ABA);
        expect_pulse(e0 + 21, M_ABA);
        expect_pulse(e0 + 29, M_ABA);
        expect_pulse(e0 + 37, M_ABA);
        expect_pulse(e0 + 45, M_ABA);
        wait_edge(e0 + 44);
        b_aba = 1'b0;
        repeat (20) @(negedge Clk);

        // 5: Select and Izquierda together; Izquierda only repeats.
        e0 = edge_cnt + 1;
        b_sel = 1'b1;
        b_izq = 1'b1;
        expect_pulse(e0 + 5, M_SEL);
        expect_pulse(e0 + 21, M_IZQ);
        expect_pulse(e0 + 29, M_IZQ);
        wait_edge(e0 + 29);
        b_sel = 1'b0;
        b_izq = 1'b0;
        repeat (20) @(negedge Clk);

        // 6: Reset in the middle of a repeating Derecha hold.
        e0 = edge_cnt + 1;
        b_der = 1'b1;
        expect_pulse(e0 + 5, M_DER);
        expect_pulse(e0 + 21, M_DER);
        wait_edge(e0 + 28);
        @(posedge Clk);
        #1;
        checks++;
        if (Derecha !== 1'b1) begin
            errors++;
            $display("FAIL repeat_before_reset: got Derecha=%b, want 1 (edge %0d)",
                     Derecha, edge_cnt);
        end
        Reset = 1'b1;
        #1;
        checks++;
        if (w_out != 5'b0) begin
            errors++;
            $display("FAIL async_reset_clear: got %b, want 00000", w_out);
        end
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        er = edge_cnt + 1;
        expect_pulse(er + 5, M_DER);
        expect_pulse(er + 21, M_DER);
        wait_edge(er + 22);
        b_der = 1'b0;
        repeat (20) @(negedge Clk);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_pulses: got %0d still pending, want 0 (next %b at edge %0d)",
                     exp_q.size(), exp_q[0].mask, exp_q[0].edge_n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
